// File: rtl/conv_operand_sequencer_if.sv
// conv_operand_sequencer_if
//  Bundles the load port, start/busy control, the A/B/acc_clr/Y connection
//  toward alu_conv and the result valid/ready port of conv_operand_sequencer.
//  Parameters:
//   DW  width of load_data, A, B
//   RW  width of Y, result
//  Modports:
//   slave  - the sequencer itself
//   master - whatever drives loads/start, models alu_conv and consumes results
interface conv_operand_sequencer_if #(
  parameter int DW = 16,
  parameter int RW = 18
);
  logic          load_valid;
  logic          load_ready;
  logic          load_sel;
  logic [DW-1:0] load_data;
  logic          start;
  logic          busy;
  logic          acc_clr;
  logic [DW-1:0] A;
  logic [DW-1:0] B;
  logic [RW-1:0] Y;
  logic [RW-1:0] result;
  logic          result_valid;
  logic          result_ready;

  modport slave (
    input  load_valid, load_sel, load_data, start, Y, result_ready,
    output load_ready, busy, acc_clr, A, B, result, result_valid
  );

  modport master (
    output load_valid, load_sel, load_data, start, Y, result_ready,
    input  load_ready, busy, acc_clr, A, B, result, result_valid
  );
endinterface

// File: rtl/conv_operand_sequencer.sv
// conv_operand_sequencer
//  Operand-side controller for the alu_conv datapath. Buffers N_TAPS samples
//  and N_TAPS coefficients, clears the accumulator, streams the buffers out as
//  A/B pairs, waits out the ALU latency, then captures Y and offers it on a
//  valid/ready result port.
//  Ports:
//   clk    sole clock, everything on posedge
//   reset  synchronous, active-high
//   bus    conv_operand_sequencer_if.slave: load port, start/busy, acc_clr,
//          A/B/Y, result/result_valid/result_ready
//  Parameters: N_TAPS (>=2), DW, RW, ALU_LAT (>=1)
//  Build option: CONV_SLIDE_EN
//   defined   - sliding window: after each result the samples shift down one
//               place and a single new sample write re-arms the next start
//   undefined - block mode: after each result all samples must be reloaded
module conv_operand_sequencer #(
  parameter int N_TAPS  = 4,
  parameter int DW      = 16,
  parameter int RW      = 18,
  parameter int ALU_LAT = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  conv_operand_sequencer_if.slave bus
);

  localparam int CW = $clog2(N_TAPS + 1);
  localparam int IW = $clog2(N_TAPS);
  localparam int WW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

  localparam logic [CW-1:0] FULL      = CW'(N_TAPS);
  localparam logic [IW-1:0] LAST_IDX  = IW'(N_TAPS - 1);
  localparam logic [WW-1:0] LAST_WAIT = WW'(ALU_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_ISSUE,
    S_WAIT,
    S_OUT
  } state_t;

  state_t        r_state;
  state_t        w_stateNext;
  logic [IW-1:0] r_idx;
  logic [IW-1:0] w_idxNext;
  logic [WW-1:0] r_wait;
  logic [DW-1:0] r_sample [N_TAPS];
  logic [DW-1:0] r_coef   [N_TAPS];
  logic [CW-1:0] r_sCnt;
  logic [CW-1:0] r_cCnt;
  logic [DW-1:0] r_a;
  logic [DW-1:0] r_b;
  logic [RW-1:0] r_result;
  logic          r_resultValid;

  logic          w_loadReady;
  logic          w_loadFire;
  logic          w_canStart;
  logic          w_outFire;
  logic          w_captureY;
  logic [IW-1:0] w_sIdx;
  logic [IW-1:0] w_cIdx;

  // Loads only in IDLE, and a pending start blocks them so a load and a
  // start can never land on the same edge.
  assign w_loadReady = (r_state == S_IDLE) && !bus.start;
  assign w_loadFire  = bus.load_valid && w_loadReady;
  assign w_canStart  = bus.start && (r_sCnt == FULL) && (r_cCnt == FULL);
  assign w_outFire   = (r_state == S_OUT) && bus.result_ready;
  assign w_captureY  = (r_state == S_WAIT) && (r_wait == LAST_WAIT);

  // The count doubles as the write pointer; a write into a full buffer
  // starts it over at index 0.
  assign w_sIdx = (r_sCnt == FULL) ? '0 : r_sCnt[IW-1:0];
  assign w_cIdx = (r_cCnt == FULL) ? '0 : r_cCnt[IW-1:0];

  // Next-state and issue-index logic. The issue index for the coming cycle
  // is produced here so the A/B registers can be loaded one edge early.
  always_comb begin
    w_stateNext = r_state;
    w_idxNext   = r_idx;
    case (r_state)
      S_IDLE: begin
        if (w_canStart) w_stateNext = S_CLR;
      end
      S_CLR: begin
        w_stateNext = S_ISSUE;
        w_idxNext   = '0;
      end
      S_ISSUE: begin
        if (r_idx == LAST_IDX) w_stateNext = S_WAIT;
        else                   w_idxNext   = r_idx + 1'b1;
      end
      S_WAIT: begin
        if (r_wait == LAST_WAIT) w_stateNext = S_OUT;
      end
      S_OUT: begin
        if (bus.result_ready) w_stateNext = S_IDLE;
      end
      default: w_stateNext = S_IDLE;
    endcase
  end

  // State register plus the registered datapath outputs. A/B are loaded
  // from the buffers on the edge that enters each ISSUE cycle so they are
  // clean registers and read zero everywhere else.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_idx         <= '0;
      r_wait        <= '0;
      r_a           <= '0;
      r_b           <= '0;
      r_result      <= '0;
      r_resultValid <= 1'b0;
    end else begin
      r_state <= w_stateNext;
      r_idx   <= w_idxNext;
      r_wait  <= (r_state == S_WAIT && !w_captureY) ? r_wait + 1'b1 : '0;
      if (w_stateNext == S_ISSUE) begin
        r_a <= r_sample[w_idxNext];
        r_b <= r_coef[w_idxNext];
      end else begin
        r_a <= '0;
        r_b <= '0;
      end
      if (w_captureY) begin
        r_result      <= bus.Y;
        r_resultValid <= 1'b1;
      end else if (w_outFire) begin
        r_resultValid <= 1'b0;
      end
    end
  end

  // Operand buffers and their counts. Coefficients survive a completed
  // convolution; what happens to the samples depends on CONV_SLIDE_EN.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sCnt <= '0;
      r_cCnt <= '0;
    end else if (w_loadFire) begin
      if (bus.load_sel) begin
        r_coef[w_cIdx] <= bus.load_data;
        r_cCnt         <= (r_cCnt == FULL) ? CW'(1) : r_cCnt + 1'b1;
      end else begin
        r_sample[w_sIdx] <= bus.load_data;
        r_sCnt           <= (r_sCnt == FULL) ? CW'(1) : r_sCnt + 1'b1;
      end
    end else if (w_outFire) begin
`ifdef CONV_SLIDE_EN
      for (int i = 0; i < N_TAPS - 1; i++) begin
        r_sample[i] <= r_sample[i+1];
      end
      r_sCnt <= CW'(N_TAPS - 1);
`else
      r_sCnt <= '0;
`endif
    end
  end

  assign bus.load_ready   = w_loadReady;
  assign bus.busy         = (r_state != S_IDLE);
  assign bus.acc_clr      = (r_state == S_CLR);
  assign bus.A            = r_a;
  assign bus.B            = r_b;
  assign bus.result       = r_result;
  assign bus.result_valid = r_resultValid;

endmodule

// File: tb/tb_conv_operand_sequencer.sv
// tb_conv_operand_sequencer
//  Self-checking bench for conv_operand_sequencer. Contains a small alu_conv
//  model (accumulate A*B since acc_clr, ALU_LAT cycles to Y), a table of
//  convolution vectors and hand-written corner-case sequences.
module tb_conv_operand_sequencer;
  localparam int N_TAPS  = 4;
  localparam int DW      = 16;
  localparam int RW      = 18;
  localparam int ALU_LAT = 2;

  typedef logic [N_TAPS-1:0][DW-1:0] ops_t;

  typedef struct {
    ops_t          s;
    ops_t          c;
    logic [RW-1:0] exp;
    int            hold;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad = 0;
  logic [RW-1:0] expQ[$];
  vec_t vecs[5];

  always #5 clk = ~clk;

  conv_operand_sequencer_if #(.DW(DW), .RW(RW)) bus ();

  conv_operand_sequencer #(
    .N_TAPS(N_TAPS), .DW(DW), .RW(RW), .ALU_LAT(ALU_LAT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  // alu_conv model: accumulator register followed by one pipeline stage,
  // so the last product appears on Y ALU_LAT cycles after its A/B pair.
  logic [RW-1:0]   acc;
  logic [RW-1:0]   yDly;
  logic [2*DW-1:0] prod;
  assign prod  = bus.A * bus.B;
  assign bus.Y = yDly;

  always @(posedge clk) begin
    if (reset || bus.acc_clr) acc <= '0;
    else                      acc <= acc + prod[RW-1:0];
    yDly <= acc;
  end

  function automatic ops_t pack4(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                 input logic [DW-1:0] c, input logic [DW-1:0] d);
    ops_t r;
    r[0] = a; r[1] = b; r[2] = c; r[3] = d;
    return r;
  endfunction

  // One comparison: counts it, reports a FAIL line on mismatch.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic resetDut();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic loadWord(input logic sel, input logic [DW-1:0] data);
    bus.load_valid = 1'b1;
    bus.load_sel   = sel;
    bus.load_data  = data;
    @(posedge clk);
    #1 bus.load_valid = 1'b0;
  endtask

  task automatic loadAll(input ops_t s, input ops_t c);
    for (int i = 0; i < N_TAPS; i++) loadWord(1'b0, s[i]);
    for (int i = 0; i < N_TAPS; i++) loadWord(1'b1, c[i]);
  endtask

  // Runs one full convolution: start, check the CLR/ISSUE sequence, wait
  // (bounded) for result_valid, compare against the scoreboard, optionally
  // hold off result_ready, then handshake. junk holds a coefficient load of
  // 0x00FF on the load port for the whole busy period.
  task automatic applyStimulus(input ops_t s, input ops_t c, input logic [RW-1:0] exp,
                               input int hold, input logic junk);
    int n;
    logic [RW-1:0] e;
    bus.start = 1'b1;
    if (junk) begin
      bus.load_valid = 1'b1;
      bus.load_sel   = 1'b1;
      bus.load_data  = 16'h00FF;
    end
    expQ.push_back(exp);
    @(posedge clk);
    #1 bus.start = 1'b0;
    @(negedge clk);
    checkOutput("clr acc_clr", bus.acc_clr, 1);
    checkOutput("clr A", bus.A, 0);
    checkOutput("clr B", bus.B, 0);
    checkOutput("clr busy", bus.busy, 1);
    for (int i = 0; i < N_TAPS; i++) begin
      @(negedge clk);
      checkOutput("issue A", bus.A, s[i]);
      checkOutput("issue B", bus.B, c[i]);
      checkOutput("issue acc_clr", bus.acc_clr, 0);
      if (junk) checkOutput("busy load_ready", bus.load_ready, 0);
    end
    n = 0;
    while (!bus.result_valid && n < 20) begin
      @(negedge clk);
      n++;
      if (!bus.result_valid) checkOutput("wait A", bus.A, 0);
    end
    checkOutput("valid latency", n, ALU_LAT + 1);
    if (expQ.size() == 0) begin
      checkOutput("scoreboard empty", 1, 0);
      e = '0;
    end else begin
      e = expQ.pop_front();
      checkOutput("result", bus.result, e);
    end
    repeat (hold) begin
      @(negedge clk);
      checkOutput("hold valid", bus.result_valid, 1);
      checkOutput("hold result", bus.result, e);
      checkOutput("hold busy", bus.busy, 1);
    end
    bus.result_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.result_ready = 1'b0;
    bus.load_valid   = 1'b0;
    @(negedge clk);
    checkOutput("post valid", bus.result_valid, 0);
    checkOutput("post busy", bus.busy, 0);
  endtask

  // Pulses start when it must be ignored and checks nothing happens.
  task automatic startIgnored(input string name);
    bus.start = 1'b1;
    @(negedge clk);
    checkOutput({name, " load_ready during start"}, bus.load_ready, 0);
    @(posedge clk);
    #1 bus.start = 1'b0;
    @(negedge clk);
    checkOutput({name, " busy"}, bus.busy, 0);
    checkOutput({name, " A"}, bus.A, 0);
    checkOutput({name, " B"}, bus.B, 0);
    checkOutput({name, " load_ready"}, bus.load_ready, 1);
  endtask

  initial begin
    bus.load_valid   = 1'b0;
    bus.load_sel     = 1'b0;
    bus.load_data    = '0;
    bus.start        = 1'b0;
    bus.result_ready = 1'b0;

    vecs[0] = '{pack4(2, 3, 4, 5), pack4(1, 1, 1, 1), 18'd14, 0};
    vecs[1] = '{pack4(2, 2, 2, 2), pack4(3, 3, 3, 3), 18'd24, 5};
    vecs[2] = '{pack4(100, 200, 300, 400), pack4(10, 20, 30, 40), 18'd30000, 1};
    vecs[3] = '{pack4(511, 511, 511, 511), pack4(511, 511, 511, 511), 18'd258052, 0};
    vecs[4] = '{pack4(16'hFFFF, 0, 1, 7), pack4(16'hFFFF, 9, 0, 3), 18'd131094, 2};

    // Reset state
    resetDut();
    @(negedge clk);
    checkOutput("reset busy", bus.busy, 0);
    checkOutput("reset A", bus.A, 0);
    checkOutput("reset B", bus.B, 0);
    checkOutput("reset acc_clr", bus.acc_clr, 0);
    checkOutput("reset result", bus.result, 0);
    checkOutput("reset result_valid", bus.result_valid, 0);
    checkOutput("reset load_ready", bus.load_ready, 1);

    // Table-driven convolutions, each from a fresh reset
    for (int v = 0; v < 5; v++) begin
      resetDut();
      loadAll(vecs[v].s, vecs[v].c);
      applyStimulus(vecs[v].s, vecs[v].c, vecs[v].exp, vecs[v].hold, 1'b0);
    end

    // Partial sample buffer: start ignored
    resetDut();
    for (int i = 0; i < 3; i++) loadWord(1'b0, 16'(i + 1));
    for (int i = 0; i < N_TAPS; i++) loadWord(1'b1, 16'd1);
    startIgnored("partial");

    // Reset during the second ISSUE cycle
    resetDut();
    loadAll(pack4(2, 3, 4, 5), pack4(1, 1, 1, 1));
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    checkOutput("preabort A", bus.A, 3);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checkOutput("abort A", bus.A, 0);
    checkOutput("abort B", bus.B, 0);
    checkOutput("abort busy", bus.busy, 0);
    checkOutput("abort result_valid", bus.result_valid, 0);
    startIgnored("after abort");

    // Post-op sample rule: one new sample after a completed run
    resetDut();
    loadAll(pack4(2, 3, 4, 5), pack4(1, 1, 1, 1));
    applyStimulus(pack4(2, 3, 4, 5), pack4(1, 1, 1, 1), 18'd14, 0, 1'b0);
    loadWord(1'b0, 16'd6);
`ifdef CONV_SLIDE_EN
    applyStimulus(pack4(3, 4, 5, 6), pack4(1, 1, 1, 1), 18'd18, 0, 1'b0);
`else
    startIgnored("block reload");
`endif

    // Loads held during a busy run are refused; rerun gives the same result
    resetDut();
    loadAll(pack4(2, 2, 2, 2), pack4(3, 3, 3, 3));
    applyStimulus(pack4(2, 2, 2, 2), pack4(3, 3, 3, 3), 18'd24, 1, 1'b1);
`ifdef CONV_SLIDE_EN
    loadWord(1'b0, 16'd2);
`else
    for (int i = 0; i < N_TAPS; i++) loadWord(1'b0, 16'd2);
`endif
    applyStimulus(pack4(2, 2, 2, 2), pack4(3, 3, 3, 3), 18'd24, 0, 1'b0);

    // Writing past a full buffer restarts it at index 0
    resetDut();
    for (int i = 0; i < N_TAPS; i++) loadWord(1'b0, 16'd9);
    loadAll(pack4(1, 2, 3, 4), pack4(1, 1, 1, 1));
    applyStimulus(pack4(1, 2, 3, 4), pack4(1, 1, 1, 1), 18'd10, 0, 1'b0);

    checkOutput("scoreboard drained", expQ.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
